// File: rtl/conv_sequencer.sv
// Frame scheduler for the 3x3 convolution datapath: walks window positions in raster
// order, steps the MAC phases and hands each finished pixel downstream on valid/ready.
module conv_sequencer #(
    parameter int H = 28,
    parameter int W = 28
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       patch_valid,
    input  logic       out_ready,
    output logic       load,
    output logic [4:0] i,
    output logic [4:0] j,
    output logic [1:0] mux_sel,
    output logic       acc_enable,
    output logic       flush_acc,
    output logic       out_valid,
    output logic       busy,
    output logic       done
);

    // state | meaning
    // IDLE  | waiting for start, all outputs low
    // LOAD  | one-cycle fetch strobe for window (i, j)
    // WAIT  | waiting for the loader to report a full patch
    // MAC0  | accumulate products of mux phase 0
    // MAC1  | accumulate products of mux phase 1
    // MAC2  | accumulate products of mux phase 2
    // OUT   | finished pixel presented until downstream accepts
    // DONE  | one-cycle end-of-frame pulse
    typedef enum logic [2:0] {
        IDLE, LOAD, WAIT, MAC0, MAC1, MAC2, OUT, DONE
    } state_t;

    localparam logic [4:0] I_LAST = 5'(H - 3);
    localparam logic [4:0] J_LAST = 5'(W - 3);

    state_t state;

    // The clear must land on the accepting cycle itself, otherwise a stalled pixel
    // would be wiped before downstream takes it; this is the only input-gated output.
    assign flush_acc = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            i          <= '0;
            j          <= '0;
            load       <= 1'b0;
            mux_sel    <= 2'd0;
            acc_enable <= 1'b0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                        load  <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    state <= WAIT;
                    load  <= 1'b0;
                end
                WAIT: begin
                    if (patch_valid) begin
                        state      <= MAC0;
                        acc_enable <= 1'b1;
                        mux_sel    <= 2'd0;
                    end
                end
                MAC0: begin
                    state   <= MAC1;
                    mux_sel <= 2'd1;
                end
                MAC1: begin
                    state   <= MAC2;
                    mux_sel <= 2'd2;
                end
                MAC2: begin
                    state      <= OUT;
                    mux_sel    <= 2'd0;
                    acc_enable <= 1'b0;
                    out_valid  <= 1'b1;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (i == I_LAST && j == J_LAST) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= LOAD;
                            load  <= 1'b1;
                            if (j == J_LAST) begin
                                j <= '0;
                                i <= i + 5'd1;
                            end else begin
                                j <= j + 5'd1;
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    i     <= '0;
                    j     <= '0;
                end
                default: begin
                    state      <= IDLE;
                    i          <= '0;
                    j          <= '0;
                    load       <= 1'b0;
                    mux_sel    <= 2'd0;
                    acc_enable <= 1'b0;
                    out_valid  <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench for conv_sequencer: a 4x4 instance for timing/stall/reset cases and
// a default 28x28 instance for a full-frame run.
module tb_conv_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    logic start4, start28;
    logic patch_valid, out_ready;

    logic       load4, acc4, flush4, ov4, busy4, done4;
    logic [4:0] i4, j4;
    logic [1:0] mux4;
    logic       load28, acc28, flush28, ov28, busy28, done28;
    logic [4:0] i28, j28;
    logic [1:0] mux28;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    conv_sequencer #(.H(4), .W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .patch_valid(patch_valid),
        .out_ready(out_ready), .load(load4), .i(i4), .j(j4), .mux_sel(mux4),
        .acc_enable(acc4), .flush_acc(flush4), .out_valid(ov4), .busy(busy4), .done(done4)
    );

    conv_sequencer dut28 (
        .clk(clk), .rst_n(rst_n), .start(start28), .patch_valid(patch_valid),
        .out_ready(out_ready), .load(load28), .i(i28), .j(j28), .mux_sel(mux28),
        .acc_enable(acc28), .flush_acc(flush28), .out_valid(ov28), .busy(busy28), .done(done28)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int outs4();
        return int'({load4, i4, j4, mux4, acc4, flush4, ov4, busy4, done4});
    endfunction

    // One 4x4 frame starting from a negedge; stalls given as inclusive cycle ranges
    // (lo = 0 means none). Cycle 0 is the cycle in which start is sampled.
    task automatic run4(input string name, input int pv_lo, input int pv_hi,
                        input int or_lo, input int or_hi, input int restart_c,
                        input int reset_c);
        int cyc, n_hs, n_load, n_flush, done_c, mac0_c, pv_len, or_len;
        int hs_c[4], hs_i[4], hs_j[4];
        int mux_at[6];
        pv_len  = (pv_lo > 0) ? pv_hi - pv_lo + 1 : 0;
        or_len  = (or_lo > 0) ? or_hi - or_lo + 1 : 0;
        n_hs = 0; n_load = 0; n_flush = 0; done_c = -1; mac0_c = -1;
        for (int k = 0; k < 6; k++) mux_at[k] = -1;
        cyc = 0;
        start4 = 1'b1;
        patch_valid = 1'b1;
        out_ready = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk);
            cyc++;
            #1;
            start4      = (cyc == restart_c);
            patch_valid = !(pv_lo > 0 && cyc >= pv_lo && cyc <= pv_hi);
            out_ready   = !(or_lo > 0 && cyc >= or_lo && cyc <= or_hi);
            @(negedge clk);
            if (cyc == 1) chk({name, " busy_rise"}, busy4, 1);
            if (cyc < 6) mux_at[cyc] = acc4 ? mux4 : -1;
            if (load4) n_load++;
            if (flush4) n_flush++;
            if (acc4 && mux4 == 2'd0 && mac0_c < 0) mac0_c = cyc;
            if (ov4 && out_ready) begin
                if (n_hs < 4) begin
                    hs_c[n_hs] = cyc; hs_i[n_hs] = i4; hs_j[n_hs] = j4;
                end
                n_hs++;
            end
            if (or_lo > 0 && cyc >= or_lo && cyc <= or_hi) begin
                chk({name, " stall_valid"}, ov4, 1);
                chk({name, " stall_ij"}, {i4, j4}, {5'd0, 5'd1});
                chk({name, " stall_flush"}, flush4, 0);
            end
            if (cyc == reset_c) begin
                chk({name, " in_mac1"}, mux4, 1);
                rst_n = 1'b0;
                #1;
                chk({name, " async_clear"}, outs4(), 0);
                break;
            end
            if (done4) begin
                done_c = cyc;
                break;
            end
        end
        if (reset_c > 0) begin
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            for (int n = 0; n < 5; n++) begin
                @(negedge clk);
                chk({name, " idle_after_reset"}, {busy4, load4, acc4}, 0);
            end
        end else begin
            chk({name, " done_cycle"}, done_c, 25 + pv_len + or_len);
            chk({name, " handshakes"}, n_hs, 4);
            chk({name, " flushes"}, n_flush, 4);
            chk({name, " loads"}, n_load, 4);
            chk({name, " mac0_cycle"}, mac0_c, 3 + pv_len);
            for (int k = 0; k < 4 && k < n_hs; k++) begin
                chk({name, " hs_cycle"}, hs_c[k], 6 * (k + 1) + pv_len + ((k >= 1) ? or_len : 0));
                chk({name, " hs_ij"}, {hs_i[k], hs_j[k]}, {k / 2, k % 2} );
            end
            if (pv_len == 0) begin
                chk({name, " mux_c3"}, mux_at[3], 0);
                chk({name, " mux_c4"}, mux_at[4], 1);
                chk({name, " mux_c5"}, mux_at[5], 2);
            end
            @(negedge clk);
            chk({name, " busy_fall"}, busy4, 0);
            chk({name, " done_pulse"}, done4, 0);
        end
    endtask

    task automatic run28();
        int cyc, n_hs, n_wrap, n_order, done_c, ei, ej;
        n_hs = 0; n_wrap = 0; n_order = 0; done_c = -1; ei = 0; ej = 0;
        cyc = 0;
        start28 = 1'b1;
        patch_valid = 1'b1;
        out_ready = 1'b1;
        for (int n = 0; n < 5000; n++) begin
            @(posedge clk);
            cyc++;
            #1;
            start28 = 1'b0;
            @(negedge clk);
            if (ov28) begin
                n_hs++;
                if (i28 != 5'(ei) || j28 != 5'(ej)) n_order++;
                if (ej == 25) begin
                    ej = 0;
                    ei++;
                end else begin
                    ej++;
                end
            end
            if (load28 && j28 == 5'd0 && i28 != 5'd0) n_wrap++;
            if (done28) begin
                done_c = cyc;
                break;
            end
        end
        chk("f28 handshakes", n_hs, 676);
        chk("f28 done_cycle", done_c, 4057);
        chk("f28 raster_errors", n_order, 0);
        chk("f28 row_wraps", n_wrap, 25);
    endtask

    initial begin
        rst_n = 1'b0;
        start4 = 1'b0;
        start28 = 1'b0;
        patch_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("reset_outputs", outs4(), 0);
        chk("reset_busy28", busy28, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run4("nominal",   0, 0,  0,  0,  0,  0);
        run4("pv_stall",  2, 6,  0,  0,  0,  0);
        run4("or_stall",  0, 0, 12, 14,  0,  0);
        run4("restart",   0, 0,  0,  0, 10,  0);
        run4("reset_mid", 0, 0,  0,  0,  0, 16);
        run4("post_reset",0, 0,  0,  0,  0,  0);
        run28();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
